// File: rtl/rv_regfile_adder.sv
// rtl/rv_regfile_adder.sv - NREG x XLEN register file (2R/1W, x0 hardwired zero) plus a combinational adder
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst            asynchronous active-low reset, clears every register
//   raddr1/rdata1  read port 1, combinational
//   raddr2/rdata2  read port 2, combinational
//   we/waddr/wdata write port, takes effect on the rising edge
//   src1/src2      adder operands
//   result         (src1 + src2) mod 2^XLEN
module rv_regfile_adder #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // Writes to x0 are dropped here; the read mux also forces x0 to zero
    // so the architectural guarantee does not depend on the storage.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write-to-read bypass: reads see the stored value until the edge.
    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

    assign result = src1 + src2;

endmodule

// File: tb/tb_rv_regfile_adder.sv
// tb/tb_rv_regfile_adder.sv - directed and randomised self-checking bench for rv_regfile_adder
module tb_rv_regfile_adder;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    logic            clk;
    logic            rst;
    logic [4:0]      raddr1;
    logic [XLEN-1:0] rdata1;
    logic [4:0]      raddr2;
    logic [XLEN-1:0] rdata2;
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] result;

    int tests_run;
    int tests_failed;

    logic [XLEN-1:0] model [NREG];

    rv_regfile_adder #(
        .XLEN(XLEN),
        .NREG(NREG)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .raddr2(raddr2),
        .rdata2(rdata2),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .src1  (src1),
        .src2  (src2),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_check(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [XLEN-1:0] exp);
        src1 = a;
        src2 = b;
        #1;
        check(tag, result, exp);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst    = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;
        src1   = '0;
        src2   = '0;
        for (int i = 0; i < NREG; i++) model[i] = '0;

        // Reset pulse; reads and adder checked while held.
        #2 rst = 1'b0;
        raddr1 = 5'd9;
        raddr2 = 5'd31;
        add_check("add_in_reset", 64'd10, 64'd20, 64'd30);
        check("rst_rd1", rdata1, '0);
        check("rst_rd2", rdata2, '0);
        tick();
        rst = 1'b1;
        #1;

        for (int a = 0; a < NREG; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(NREG - 1 - a);
            #1;
            check($sformatf("post_rst_rd1_%0d", a), rdata1, '0);
            check($sformatf("post_rst_rd2_%0d", NREG - 1 - a), rdata2, '0);
        end

        // Write x5 with same-cycle read of x5 (no bypass).
        we = 1'b1; waddr = 5'd5; wdata = 64'h0000_0000_DEAD_BEEF; raddr1 = 5'd5;
        #1;
        check("x5_same_cycle_old", rdata1, '0);
        tick();
        check("x5_after_edge", rdata1, 64'h0000_0000_DEAD_BEEF);

        waddr = 5'd31; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd31;
        #1;
        check("rd1_x5", rdata1, 64'h0000_0000_DEAD_BEEF);
        check("rd2_x31", rdata2, 64'hFFFF_FFFF_FFFF_FFFF);
        raddr2 = 5'd5;
        #1;
        check("same_addr_rd2", rdata2, rdata1 === 64'h0000_0000_DEAD_BEEF ? 64'h0000_0000_DEAD_BEEF : 64'h0);

        // x0 immunity and we=0 hold.
        we = 1'b1; waddr = 5'd0; wdata = 64'h1234;
        tick();
        we = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        check("x0_rd1", rdata1, '0);
        check("x0_rd2", rdata2, '0);
        waddr = 5'd7; wdata = 64'h1234;
        tick();
        raddr1 = 5'd7;
        #1;
        check("x7_we0", rdata1, '0);

        // Asynchronous reset between edges, then a write attempted under reset.
        raddr1 = 5'd5;
        #1;
        check("x5_before_async", rdata1, 64'h0000_0000_DEAD_BEEF);
        rst = 1'b0;
        #1;
        check("x5_async_cleared", rdata1, '0);
        we = 1'b1; waddr = 5'd5; wdata = 64'hCAFE;
        tick();
        check("write_in_reset_rd", rdata1, '0);
        we = 1'b0;
        rst = 1'b1;
        #1;
        check("write_in_reset_dropped", rdata1, '0);
        raddr1 = 5'd31;
        #1;
        check("x31_cleared", rdata1, '0);

        // First write after release lands on the first edge.
        we = 1'b1; waddr = 5'd3; wdata = 64'h55;
        tick();
        we = 1'b0; raddr1 = 5'd3;
        #1;
        check("first_write_after_rst", rdata1, 64'h55);
        model[3] = 64'h55;

        // Adder.
        add_check("add_3_4", 64'd3, 64'd4, 64'd7);
        add_check("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        add_check("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000);
        add_check("add_neg", 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFC);

        // Random stress; small address range in alternate cycles forces collisions.
        for (int c = 0; c < 1000; c++) begin
            int hi;
            hi = (c % 2 == 0) ? 3 : 31;
            we     = 1'($urandom_range(0, 1));
            waddr  = 5'($urandom_range(0, hi));
            wdata  = {$urandom, $urandom};
            raddr1 = 5'($urandom_range(0, hi));
            raddr2 = (c % 5 == 0) ? raddr1 : 5'($urandom_range(0, hi));
            #1;
            check($sformatf("rnd_rd1_c%0d", c), rdata1, model[raddr1]);
            check($sformatf("rnd_rd2_c%0d", c), rdata2, model[raddr2]);
            tick();
            if (we && waddr != 5'd0) model[waddr] = wdata;
        end
        we = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
